// File: rtl/seg7_display.sv
// Multi-digit seven-segment display controller.
// Accepts a binary value over valid/ready, converts it to BCD with a
// sequential double-dabble engine (decimal mode) or passes nibbles through
// (hex mode), then registers an active-low segment image for every digit.
// Supports leading-zero blanking and a dash pattern on decimal overflow.
module seg7_display #(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [VALUE_W-1:0]      in_value,
    input  logic                    in_hex,
    input  logic                    in_blank_lz,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7*NUM_DIGITS-1:0] leds,
    output logic                    busy
);

    // Each 3 input bits produce less than one decimal digit, so ceil(VALUE_W/3)
    // BCD digits always hold the full conversion without truncation.
    localparam int GUARD_DIGITS = (VALUE_W + 2) / 3;
    localparam int BCD_DIGITS   = (NUM_DIGITS > GUARD_DIGITS) ? NUM_DIGITS : GUARD_DIGITS;
    localparam int BCD_W        = 4 * BCD_DIGITS;
    localparam int HEX_W        = 4 * NUM_DIGITS;
    localparam int PAD_W        = (VALUE_W > HEX_W) ? VALUE_W : HEX_W;
    localparam int CNT_W        = $clog2(VALUE_W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [63:0] pow10_minus1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    // Largest decimal value that fits the display, and largest input value.
    localparam logic [63:0] DEC_LIMIT    = pow10_minus1(NUM_DIGITS);
    localparam logic [63:0] IN_MAX       = (VALUE_W >= 64) ? '1 : ((64'd1 << VALUE_W) - 64'd1);
    localparam bit          OVF_POSSIBLE = IN_MAX > DEC_LIMIT;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t                  state;
    logic                    ready_q;
    logic [7*NUM_DIGITS-1:0] leds_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [VALUE_W-1:0]      shift_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;
    logic                    hex_q;
    logic                    blank_q;

    logic                    ovf_next;
    logic [BCD_W-1:0]        bcd_adj;
    logic [PAD_W-1:0]        val_ext;
    logic [3:0]              digit [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] image;

    // Overflow is only checkable when the input range exceeds the display range.
    generate
        if (OVF_POSSIBLE) begin : g_ovf
            assign ovf_next = 64'(in_value) > DEC_LIMIT;
        end else begin : g_no_ovf
            assign ovf_next = 1'b0;
        end
    endgenerate

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
    end

    // In hex mode the shift register holds the latched value; nibbles past VALUE_W read 0.
    assign val_ext = PAD_W'(shift_q);

    // Select the digit source for the current mode.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit[i] = hex_q ? val_ext[4*i +: 4] : bcd_q[4*i +: 4];
        end
    end

    // Build the segment image, scanning from the top digit to track leading zeros.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no latch is inferred.
        logic lead;
        image = '0;
        lead  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (digit[i] != 4'd0) lead = 1'b0;
            if (ovf_q && !hex_q)                image[7*i +: 7] = SEG_DASH;
            else if (blank_q && lead && i != 0) image[7*i +: 7] = SEG_BLANK;
            else                                image[7*i +: 7] = glyph(digit[i]);
        end
    end

    // Control FSM plus conversion datapath; all outputs come straight from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            leds_q  <= '1;
            bcd_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            hex_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && ready_q) begin
                        hex_q   <= in_hex;
                        blank_q <= in_blank_lz;
                        shift_q <= in_value;
                        ready_q <= 1'b0;
                        if (in_hex) begin
                            ovf_q <= 1'b0;
                            state <= LOAD;
                        end else begin
                            ovf_q <= ovf_next;
                            bcd_q <= '0;
                            cnt_q <= CNT_W'(VALUE_W);
                            state <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    {bcd_q, shift_q} <= {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
                    cnt_q            <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state <= LOAD;
                end
                LOAD: begin
                    leds_q  <= image;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign busy     = ~ready_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_seg7_display.sv
// Directed testbench for seg7_display with default parameters (6 digits, 20 bits).
module tb_seg7_display;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G6 = 7'b0000010, G7 = 7'b1111000, G9 = 7'b0010000,
                           GA = 7'b0001000, GB = 7'b0000011, GC = 7'b1000110,
                           GD = 7'b0100001, GE = 7'b0000110,
                           BL = 7'b1111111, DA = 7'b0111111;

    localparam logic [41:0] ALL_BLANK = 42'h3FF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] in_value = '0;
    logic        in_hex = 1'b0;
    logic        in_blank_lz = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [41:0] leds;
    logic        busy;

    int passed = 0;
    int total  = 0;

    seg7_display dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_value   (in_value),
        .in_hex     (in_hex),
        .in_blank_lz(in_blank_lz),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .leds       (leds),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Offer one value; the transfer happens on the first rising edge with in_ready high.
    task automatic send(input logic [19:0] v, input logic hx, input logic blz);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_value    = v;
        in_hex      = hx;
        in_blank_lz = blz;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count busy cycles after an accept and note whether leds moved before the update.
    task automatic wait_done(input logic [41:0] prev, output int lows, output bit stable);
        lows   = 0;
        stable = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
            lows++;
            if (leds !== prev) stable = 1'b0;
        end
    endtask

    task automatic test_reset;
        #23;
        total++; if (leds !== ALL_BLANK) $display("FAIL reset_leds got %h want %h", leds, ALL_BLANK); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_dec_123456;
        logic [41:0] prev;
        int lows;
        bit stable;
        prev = leds;
        send(20'd123456, 1'b0, 1'b0);
        wait_done(prev, lows, stable);
        total++; if (lows != 21) $display("FAIL dec_busy_cycles got %0d want 21", lows); else passed++;
        total++; if (stable !== 1'b1) $display("FAIL dec_old_image_stable got %b want 1", stable); else passed++;
        total++; if (leds !== {G1, G2, G3, G4, G5, G6})
            $display("FAIL dec_123456 got %h want %h", leds, {G1, G2, G3, G4, G5, G6}); else passed++;
    endtask

    task automatic test_blanking;
        logic [41:0] prev;
        int lows;
        bit stable;
        prev = leds;
        send(20'd42, 1'b0, 1'b1);
        wait_done(prev, lows, stable);
        total++; if (leds !== {BL, BL, BL, BL, G4, G2})
            $display("FAIL dec_42_blank got %h want %h", leds, {BL, BL, BL, BL, G4, G2}); else passed++;
        prev = leds;
        send(20'd0, 1'b0, 1'b1);
        wait_done(prev, lows, stable);
        total++; if (leds !== {BL, BL, BL, BL, BL, G0})
            $display("FAIL dec_0_blank got %h want %h", leds, {BL, BL, BL, BL, BL, G0}); else passed++;
    endtask

    task automatic test_hex;
        logic [41:0] prev;
        int lows;
        bit stable;
        prev = leds;
        send(20'hABCDE, 1'b1, 1'b1);
        wait_done(prev, lows, stable);
        total++; if (lows != 1) $display("FAIL hex_busy_cycles got %0d want 1", lows); else passed++;
        total++; if (leds !== {BL, GA, GB, GC, GD, GE})
            $display("FAIL hex_blank got %h want %h", leds, {BL, GA, GB, GC, GD, GE}); else passed++;
        prev = leds;
        send(20'hABCDE, 1'b1, 1'b0);
        wait_done(prev, lows, stable);
        total++; if (leds !== {G0, GA, GB, GC, GD, GE})
            $display("FAIL hex_noblank got %h want %h", leds, {G0, GA, GB, GC, GD, GE}); else passed++;
    endtask

    task automatic test_overflow;
        logic [41:0] prev;
        int lows;
        bit stable;
        prev = leds;
        send(20'd1000000, 1'b0, 1'b1);
        wait_done(prev, lows, stable);
        total++; if (leds !== {6{DA}}) $display("FAIL dec_overflow got %h want %h", leds, {6{DA}}); else passed++;
        prev = leds;
        send(20'd999999, 1'b0, 1'b0);
        wait_done(prev, lows, stable);
        total++; if (leds !== {6{G9}}) $display("FAIL dec_999999 got %h want %h", leds, {6{G9}}); else passed++;
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        total++; if (leds !== ALL_BLANK) $display("FAIL async_reset_leds got %h want %h", leds, ALL_BLANK); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL async_reset_ready got %b want 1", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL async_reset_busy got %b want 0", busy); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_convert;
        send(20'd123456, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++; if (leds !== ALL_BLANK) $display("FAIL midconv_reset_leds got %h want %h", leds, ALL_BLANK); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL midconv_reset_ready got %b want 1", in_ready); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ignore_busy;
        logic [41:0] prev;
        int lows;
        bit stable;
        bit ready_held;
        prev = leds;
        send(20'd7, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        in_value = 20'd555;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(prev, lows, stable);
        total++; if (leds !== {G0, G0, G0, G0, G0, G7})
            $display("FAIL first_value_kept got %h want %h", leds, {G0, G0, G0, G0, G0, G7}); else passed++;
        ready_held = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (in_ready !== 1'b1) ready_held = 1'b0;
        end
        total++; if (ready_held !== 1'b1) $display("FAIL no_second_accept got %b want 1", ready_held); else passed++;
        total++; if (leds !== {G0, G0, G0, G0, G0, G7})
            $display("FAIL image_after_idle got %h want %h", leds, {G0, G0, G0, G0, G0, G7}); else passed++;
    endtask

    initial begin
        test_reset();
        test_dec_123456();
        test_blanking();
        test_hex();
        test_overflow();
        test_async_reset();
        test_reset_mid_convert();
        test_ignore_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
